rmt_action_engine: RTL and testbench

//  Per-stage action unit of the RMT match-action pipeline, after the lookup engine.

---
 rtl/rmt_action_engine_if.sv | 22 ++
 rtl/rmt_action_engine.sv | 126 ++++++++++++
 tb/tb_rmt_action_engine.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/rmt_action_engine_if.sv
// PHV/action bus between the lookup engine, the per-stage action unit and the next stage.
interface rmt_action_engine_if #(
   parameter int PHV_LEN = 1124,
   parameter int ACT_LEN = 25
);
   logic [PHV_LEN-1:0]     phv_in;
   logic                   phv_valid_in;
   logic [25*ACT_LEN-1:0]  action_in;
   logic                   action_valid_in;
   logic [PHV_LEN-1:0]     phv_out;
   logic                   phv_valid_out;

   modport master (
      output phv_in, phv_valid_in, action_in, action_valid_in,
      input  phv_out, phv_valid_out
   );

   modport slave (
      input  phv_in, phv_valid_in, action_in, action_valid_in,
      output phv_out, phv_valid_out
   );
endinterface

// File: rtl/rmt_action_engine.sv
// RMT per-stage action unit: 24 container ALUs over one PHV, fixed 2-cycle latency.
// Optional 16x32 state memory on slot 16 (con_4B_7) when ACTION_STATE_MEM_EN is defined.
module rmt_action_engine #(
   parameter int STAGE   = 0,
   parameter int PHV_LEN = 1124,
   parameter int ACT_LEN = 25
) (
   input  logic                 clk,
   input  logic                 rst,
   rmt_action_engine_if.slave   bus
);
   localparam int unused_stage = STAGE;

   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_SUB   = 4'b0010;
   localparam logic [3:0] OP_STORE = 4'b1000;
   localparam logic [3:0] OP_ADDI  = 4'b1001;
   localparam logic [3:0] OP_SUBI  = 4'b1010;
   localparam logic [3:0] OP_LOAD  = 4'b1011;
   localparam logic [3:0] OP_SET   = 4'b1110;

   // Only the bits an ALU consumes are kept; B is imm[13:11].
   typedef struct packed {
      logic [3:0]  op;
      logic [2:0]  a;
      logic [15:0] imm;
   } act_t;

   logic [PHV_LEN-1:0] phv_r;
   act_t [24:1]        act_r;
   act_t [24:1]        act_in;
   logic               valid_r;
   logic               unused_act;

   logic [47:0]        c6 [8];
   logic [31:0]        c4 [8];
   logic [15:0]        c2 [8];
   logic [PHV_LEN-1:0] phv_next;

   function automatic logic [47:0] alu(input act_t act, input logic [47:0] dst,
                                       input logic [47:0] ca, input logic [47:0] cb);
      logic [47:0] imm_x;
      imm_x = {32'b0, act.imm};
      case (act.op)
         OP_ADD:  return ca + cb;
         OP_SUB:  return ca - cb;
         OP_ADDI: return ca + imm_x;
         OP_SUBI: return ca - imm_x;
         OP_SET:  return imm_x;
         default: return dst;
      endcase
   endfunction

   always_comb begin
      logic [24:0] slot;
      slot       = '0;
      act_in     = '0;
      unused_act = ^bus.action_in[24:0];
      for (int unsigned s = 1; s < 25; s++) begin
         slot       = bus.action_in[ACT_LEN*s +: 25];
         act_in[s]  = '{op: slot[24:21], a: slot[18:16], imm: slot[15:0]};
         unused_act = unused_act ^ slot[20] ^ slot[19];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phv_r   <= '0;
         act_r   <= '0;
         valid_r <= 1'b0;
      end else begin
         valid_r <= bus.phv_valid_in;
         if (bus.phv_valid_in) begin
            phv_r <= bus.phv_in;
            act_r <= bus.action_valid_in ? act_in : '0;
         end
      end
   end

`ifdef ACTION_STATE_MEM_EN
   logic [31:0] state_mem [16];

   // Written at the end of the store's ALU cycle, so the very next PHV's load sees it.
   always_ff @(posedge clk) begin
      if (!rst && valid_r && act_r[16].op == OP_STORE)
         state_mem[act_r[16].imm[3:0]] <= c4[act_r[16].a];
   end
`endif

   // All operands come from phv_r, never from phv_next.
   always_comb begin
      logic [47:0] res;
      res      = '0;
      phv_next = phv_r;
      for (int unsigned k = 0; k < 8; k++) begin
         c6[k] = phv_r[740+48*k +: 48];
         c4[k] = phv_r[484+32*k +: 32];
         c2[k] = phv_r[356+16*k +: 16];
      end
      for (int unsigned k = 0; k < 8; k++) begin
         res = alu(act_r[17+k], c6[k], c6[act_r[17+k].a], c6[act_r[17+k].imm[13:11]]);
         phv_next[740+48*k +: 48] = res;
         res = alu(act_r[9+k], {16'b0, c4[k]}, {16'b0, c4[act_r[9+k].a]},
                   {16'b0, c4[act_r[9+k].imm[13:11]]});
         phv_next[484+32*k +: 32] = res[31:0];
         res = alu(act_r[1+k], {32'b0, c2[k]}, {32'b0, c2[act_r[1+k].a]},
                   {32'b0, c2[act_r[1+k].imm[13:11]]});
         phv_next[356+16*k +: 16] = res[15:0];
      end
`ifdef ACTION_STATE_MEM_EN
      if (act_r[16].op == OP_LOAD)
         phv_next[484+32*7 +: 32] = state_mem[act_r[16].imm[3:0]];
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.phv_out       <= '0;
         bus.phv_valid_out <= 1'b0;
      end else begin
         bus.phv_valid_out <= valid_r;
         if (valid_r)
            bus.phv_out <= phv_next;
      end
   end
endmodule

// File: tb/tb_rmt_action_engine.sv
// Scoreboard bench for rmt_action_engine: directed PHV/action vectors, monitor checks data and latency.
module tb_rmt_action_engine;
   typedef logic [1123:0] phv_t;
   typedef logic [624:0]  actw_t;

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   int unsigned cyc;

   phv_t        exp_q [$];
   int unsigned iss_q [$];
   phv_t        last_exp;

   rmt_action_engine_if #(.PHV_LEN(1124), .ACT_LEN(25)) bus ();

   rmt_action_engine #(.STAGE(0), .PHV_LEN(1124), .ACT_LEN(25)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic phv_t put6(input phv_t p, input int k, input logic [47:0] v);
      p[740+48*k +: 48] = v;
      return p;
   endfunction

   function automatic phv_t put4(input phv_t p, input int k, input logic [31:0] v);
      p[484+32*k +: 32] = v;
      return p;
   endfunction

   function automatic phv_t put2(input phv_t p, input int k, input logic [15:0] v);
      p[356+16*k +: 16] = v;
      return p;
   endfunction

   function automatic actw_t slot(input actw_t a, input int s, input logic [24:0] v);
      a[25*s +: 25] = v;
      return a;
   endfunction

   task automatic send(input phv_t p, input actw_t a, input logic av, input phv_t e);
      @(negedge clk);
      bus.phv_in          = p;
      bus.action_in       = a;
      bus.action_valid_in = av;
      bus.phv_valid_in    = 1'b1;
      exp_q.push_back(e);
      iss_q.push_back(cyc);
   endtask

   task automatic idle();
      @(negedge clk);
      bus.phv_valid_in    = 1'b0;
      bus.action_valid_in = 1'b0;
   endtask

   // Monitor: reset state, in-order data with 2-cycle latency, and output hold when idle.
   always @(posedge clk) begin
      phv_t        e;
      int unsigned iss;
      #1;
      if (rst) begin
         tests++;
         if (bus.phv_valid_out !== 1'b0 || bus.phv_out !== '0) begin
            fails++;
            $display("FAIL reset_state valid=%b out=%h required valid=0 out=0",
                     bus.phv_valid_out, bus.phv_out);
         end
         last_exp = '0;
      end else if (bus.phv_valid_out === 1'b1) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_output got valid with empty scoreboard, out=%h", bus.phv_out);
         end else begin
            e   = exp_q.pop_front();
            iss = iss_q.pop_front();
            last_exp = e;
            if (bus.phv_out !== e) begin
               fails++;
               $display("FAIL phv_data got=%h", bus.phv_out);
               $display("FAIL phv_data required=%h", e);
            end
            tests++;
            if (cyc - iss != 2) begin
               fails++;
               $display("FAIL latency got=%0d required=2", cyc - iss);
            end
         end
      end else begin
         tests++;
         if (bus.phv_valid_out !== 1'b0 || bus.phv_out !== last_exp) begin
            fails++;
            $display("FAIL hold valid=%b out=%h required valid=0 out=%h",
                     bus.phv_valid_out, bus.phv_out, last_exp);
         end
      end
   end

   initial begin
      phv_t  base, p, p2, e;
      actw_t a;

      tests = 0;
      fails = 0;
      last_exp = '0;
      rst = 1'b1;
      bus.phv_in = '0;
      bus.action_in = '0;
      bus.phv_valid_in = 1'b0;
      bus.action_valid_in = 1'b0;
      for (int i = 0; i < 1124; i++) base[i] = ((i * 37) % 5) < 2;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle();

      // all-zero actions: pass-through
      p = put6(put6(base, 7, 48'h111111111111), 6, 48'h222222222222);
      send(p, '0, 1'b1, p);

      // subi on con_6B_7 from con_6B_6
      p = put6(put6(base, 7, 48'hffffffffffff), 6, 48'heeeeeeeeeeee);
      a = slot('0, 24, {4'b1010, 5'd6, 16'hffff});
      send(p, a, 1'b1, put6(p, 7, 48'heeeeeeedeeef));

      // action_valid_in low: same actions become nop
      send(p, a, 1'b0, p);

      // explicit nop
      a = slot('0, 24, {4'b0000, 5'd6, 16'hffff});
      send(p, a, 1'b1, p);

      // 16-bit add wraps
      p = put2(put2(base, 0, 16'hfff0), 1, 16'h0020);
      a = slot('0, 1, {4'b0001, 5'd0, 5'd1, 11'b0});
      send(p, a, 1'b1, put2(p, 0, 16'h0010));

      // mixed slots: operands from incoming PHV, wrap, sub borrow, set, unknown op, A upper bits ignored
      p = put6(base, 1, 48'h800000000001);
      p = put4(put4(p, 2, 32'd5), 3, 32'd7);
      p = put2(p, 1, 16'h1234);
      p = put4(p, 6, 32'hcafef00d);
      a = '0;
      a = slot(a, 0, 25'h1ffffff);
      a = slot(a, 17, {4'b0001, 5'd1, 5'd1, 11'b0});
      a = slot(a, 18, {4'b1110, 5'd0, 16'h0005});
      a = slot(a, 9, {4'b0010, 5'd2, 5'd3, 11'b0});
      a = slot(a, 12, {4'b1110, 5'd0, 16'hbeef});
      a = slot(a, 2, {4'b0111, 5'd3, 16'h1111});
      a = slot(a, 3, {4'b1001, 5'd25, 16'h0003});
      a = slot(a, 15, {4'b1011, 5'd0, 16'd7});
      e = put6(put6(p, 0, 48'h000000000002), 1, 48'h000000000005);
      e = put4(put4(e, 0, 32'hfffffffe), 3, 32'h0000beef);
      e = put2(e, 2, 16'h1237);
      send(p, a, 1'b1, e);

      // store in PHV n, load in PHV n+1
      p = put4(base, 7, 32'hffffffff);
      a = slot('0, 16, {4'b1000, 5'd7, 16'd7});
      send(p, a, 1'b1, p);
      p2 = put4(base, 7, 32'h0);
      a = slot('0, 16, {4'b1011, 5'd0, 16'd7});
`ifdef ACTION_STATE_MEM_EN
      send(p2, a, 1'b1, put4(p2, 7, 32'hffffffff));
`else
      send(p2, a, 1'b1, p2);
`endif
      idle();

      // action_valid_in without phv_valid_in: no output
      @(negedge clk);
      bus.action_in = slot('0, 24, {4'b1110, 5'd0, 16'h1234});
      bus.action_valid_in = 1'b1;
      idle();
      idle();

      // back-to-back then reset mid-stream
      send(put6(base, 0, 48'h1), '0, 1'b1, put6(base, 0, 48'h1));
      send(put6(base, 0, 48'h2), '0, 1'b1, put6(base, 0, 48'h2));
      send(put6(base, 0, 48'h3), '0, 1'b1, put6(base, 0, 48'h3));
      @(negedge clk);
      rst = 1'b1;
      bus.phv_valid_in = 1'b0;
      bus.action_valid_in = 1'b0;
      exp_q.delete();
      iss_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      p = put4(base, 1, 32'h00000010);
      a = slot('0, 10, {4'b1001, 5'd1, 16'h0005});
      send(p, a, 1'b1, put4(p, 1, 32'h00000015));
      send(put6(base, 0, 48'h4), '0, 1'b1, put6(base, 0, 48'h4));
      idle();

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
